// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared types and constants for the program-counter unit.
//   pc_op_t   : 3-bit per-cycle command from the decoder / control FSM.
//               Encodings 6 and 7 are unused and behave as PC_HOLD.
//   FAULT_OVF : index of the sticky call-overflow bit in fault[].
//   FAULT_UDF : index of the sticky return-underflow bit in fault[].
// -----------------------------------------------------------------------------
package pc_pkg;

  typedef enum logic [2:0] {
    PC_INC  = 3'd0,
    PC_JMP  = 3'd1,
    PC_BR   = 3'd2,
    PC_CALL = 3'd3,
    PC_RET  = 3'd4,
    PC_HOLD = 3'd5
  } pc_op_t;

  localparam int FAULT_OVF = 0;
  localparam int FAULT_UDF = 1;

endpackage

// File: rtl/ras_stack.sv
// -----------------------------------------------------------------------------
// ras_stack
// Hardware return-address stack (LIFO) of DEPTH entries, AW bits each.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   push     : store din on top (ignored when full)
//   pop      : discard top entry (ignored when empty)
//   din      : value to push
//   dout     : current top entry (entry level-1); don't-care when empty
//   level    : occupancy 0..DEPTH
//   full     : level == DEPTH
//   empty    : level == 0
// Flags decode the registered level only, so they carry no input path.
// -----------------------------------------------------------------------------
module ras_stack
  import pc_pkg::*;
#(
  parameter int AW    = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [AW-1:0]              din,
  output logic [AW-1:0]              dout,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NE = 2 ** IW;

  logic [LW-1:0] level_q, level_d;
  logic [AW-1:0] mem_q [NE];
  logic [AW-1:0] mem_d [NE];
  logic [IW-1:0] wr_idx, rd_idx;
  logic          do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign wr_idx  = IW'(level_q);
  assign rd_idx  = IW'(level_q - 1'b1);
  assign dout    = mem_q[rd_idx];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    level_d = level_q;
    mem_d   = mem_q;
    if (do_push) begin
      mem_d[wr_idx] = din;
      level_d       = level_q + 1'b1;
    end else if (do_pop) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from pre-edge values.
    if (rst) level_q <= '0;
    else     level_q <= level_d;
  end

  // NOTE: the storage array is deliberately not reset; level alone defines
  // which entries are valid, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_stack_unit.sv
// -----------------------------------------------------------------------------
// pc_stack_unit
// Fetch-stage program counter with jump, PC-relative branch, stall and a
// return-address stack for call/return.
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   en        : advance enable; 0 freezes pc, stack and fault
//   op        : pc_op_t command (6/7 act as PC_HOLD)
//   target    : absolute destination for PC_JMP / PC_CALL
//   offset    : two's-complement displacement for PC_BR, relative to pc
//   pc        : registered program counter
//   level     : stack occupancy 0..DEPTH
//   ras_full  : level == DEPTH
//   ras_empty : level == 0
//   fault     : sticky [FAULT_OVF] call overflow, [FAULT_UDF] return underflow
// -----------------------------------------------------------------------------
module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int          AW       = 5,
  parameter int          DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [2:0]                 op,
  input  logic [AW-1:0]              target,
  input  logic [AW-1:0]              offset,
  output logic [AW-1:0]              pc,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       ras_full,
  output logic                       ras_empty,
  output logic [1:0]                 fault
);

  logic [AW-1:0] pc_q, pc_d;
  logic [1:0]    fault_q, fault_d;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] ras_top;
  logic          push, pop;

  // Return address is the instruction after the call; wraps naturally.
  assign pc_inc = pc_q + 1'b1;

  ras_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (ras_top),
    .level (level),
    .full  (ras_full),
    .empty (ras_empty)
  );

  always_comb begin
    pc_d    = pc_q;
    fault_d = fault_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (en) begin
      case (op)
        PC_INC: pc_d = pc_inc;
        PC_JMP: pc_d = target;
        PC_BR:  pc_d = pc_q + offset;
        PC_CALL: begin
          pc_d = target;
          if (ras_full) fault_d[FAULT_OVF] = 1'b1;
          else          push = 1'b1;
        end
        PC_RET: begin
          if (ras_empty) begin
            // Underflow: fall through to the next instruction and flag it.
            pc_d                = pc_inc;
            fault_d[FAULT_UDF]  = 1'b1;
          end else begin
            pc_d = ras_top;
            pop  = 1'b1;
          end
        end
        default: pc_d = pc_q;  // PC_HOLD and unused encodings
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      fault_q <= 2'b00;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  assign pc    = pc_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
module tb_pc_stack_unit;
  import pc_pkg::*;

  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [2:0]    op;
  logic [AW-1:0] target;
  logic [AW-1:0] offset;
  logic [AW-1:0] pc;
  logic [LW-1:0] level;
  logic          ras_full;
  logic          ras_empty;
  logic [1:0]    fault;

  int checks   = 0;
  int failures = 0;

  pc_stack_unit #(
    .AW       (AW),
    .DEPTH    (DEPTH),
    .RESET_PC (5'd0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .op        (op),
    .target    (target),
    .offset    (offset),
    .pc        (pc),
    .level     (level),
    .ras_full  (ras_full),
    .ras_empty (ras_empty),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one op at the falling edge, let the rising edge take it, look #1 later.
  task automatic step(input logic [2:0] o, input logic [AW-1:0] t,
                      input logic [AW-1:0] ofs, input logic e);
    @(negedge clk);
    op = o; target = t; offset = ofs; en = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; op = PC_HOLD; target = '0; offset = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 0);
    check("rst_level", level, 0);
    check("rst_empty", ras_empty, 1);
    check("rst_full", ras_full, 0);
    check("rst_fault", fault, 0);
    @(negedge clk);
    rst = 1'b0;

    // Increment through the full range and wrap.
    for (int i = 1; i <= 33; i++) begin
      step(PC_INC, 0, 0, 1'b1);
      check($sformatf("inc_%0d", i), pc, i % 32);
    end

    // Stall ignores op.
    for (int i = 0; i < 3; i++) begin
      step(PC_JMP, 5'd9, 0, 1'b0);
      check("stall_pc", pc, 1);
    end
    check("stall_level", level, 0);

    // Jump and relative branches.
    step(PC_JMP, 5'd2, 0, 1'b1);      check("jmp", pc, 2);
    step(PC_BR, 0, 5'b11101, 1'b1);   check("br_neg", pc, 31);
    step(PC_BR, 0, 5'd4, 1'b1);       check("br_pos", pc, 3);
    step(PC_INC, 0, 0, 1'b1);         check("inc_to4", pc, 4);

    // Single call / return.
    step(PC_CALL, 5'd10, 0, 1'b1);    check("call_pc", pc, 10);
    check("call_level", level, 1);
    step(PC_INC, 0, 0, 1'b1);         check("call_inc", pc, 11);
    step(PC_RET, 0, 0, 1'b1);         check("ret_pc", pc, 5);
    check("ret_level", level, 0);
    check("ret_empty", ras_empty, 1);

    // Fill the stack, overflow, then unwind.
    step(PC_JMP, 5'd0, 0, 1'b1);      check("jmp0", pc, 0);
    for (int i = 1; i <= 4; i++) begin
      step(PC_CALL, AW'(i), 0, 1'b1);
      check($sformatf("fill_pc_%0d", i), pc, i);
      check($sformatf("fill_lvl_%0d", i), level, i);
    end
    check("full_flag", ras_full, 1);
    check("fill_fault", fault, 0);
    step(PC_CALL, 5'd5, 0, 1'b1);
    check("ovf_pc", pc, 5);
    check("ovf_level", level, 4);
    check("ovf_fault", fault, 2'b01);
    for (int i = 4; i >= 1; i--) begin
      step(PC_RET, 0, 0, 1'b1);
      check($sformatf("unwind_pc_%0d", i), pc, i);
      check($sformatf("unwind_lvl_%0d", i), level, i - 1);
    end
    check("unwind_empty", ras_empty, 1);

    // Underflow and stickiness.
    step(PC_JMP, 5'd7, 0, 1'b1);      check("jmp7", pc, 7);
    step(PC_RET, 0, 0, 1'b1);         check("udf_pc", pc, 8);
    check("udf_fault", fault, 2'b11);
    check("udf_level", level, 0);
    step(PC_INC, 0, 0, 1'b1);         check("sticky_pc", pc, 9);
    check("sticky_fault", fault, 2'b11);

    // Back-to-back call then return, no bubble.
    step(PC_CALL, 5'd17, 0, 1'b1);    check("b2b_call", pc, 17);
    step(PC_RET, 0, 0, 1'b1);         check("b2b_ret", pc, 10);
    check("b2b_level", level, 0);

    // Call at the top address pushes the wrapped return address.
    step(PC_JMP, 5'd31, 0, 1'b1);     check("jmp31", pc, 31);
    step(PC_CALL, 5'd6, 0, 1'b1);     check("wrap_call", pc, 6);
    step(PC_RET, 0, 0, 1'b1);         check("wrap_ret", pc, 0);

    // Undefined encodings hold.
    step(3'd6, 5'd20, 5'd3, 1'b1);    check("op6_hold", pc, 0);
    step(3'd7, 5'd20, 5'd3, 1'b1);    check("op7_hold", pc, 0);
    step(PC_HOLD, 5'd20, 5'd3, 1'b1); check("hold", pc, 0);

    // Build level 3, then reset asynchronously between edges.
    step(PC_CALL, 5'd20, 0, 1'b1);
    step(PC_CALL, 5'd21, 0, 1'b1);
    step(PC_CALL, 5'd22, 0, 1'b1);
    check("pre_rst_pc", pc, 22);
    check("pre_rst_level", level, 3);
    check("pre_rst_fault", fault, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    check("async_pc", pc, 0);
    check("async_level", level, 0);
    check("async_fault", fault, 0);
    check("async_empty", ras_empty, 1);

    // Reset held across an edge wins over an active op.
    op = PC_INC; en = 1'b1;
    @(posedge clk); #1;
    check("rst_override", pc, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("first_op", pc, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
